// File: rtl/updown_load_counter_if.sv
// Command/status bundle for updown_load_counter.
// Latency: not applicable (wires only).
// Backpressure: none; commands are sampled every cycle.
//
// Signals:
//   load, up, down : command requests (driven by master)
//   in             : load value, WIDTH bits (driven by master)
//   count          : registered count, WIDTH bits (driven by slave)
//   high, low      : count-at-max / count-at-zero decodes (driven by slave)
interface updown_load_counter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] count;
  logic             high;
  logic             low;

  // Command source side.
  modport master (
    output load, up, down, in,
    input  count, high, low
  );

  // Counter side.
  modport slave (
    input  load, up, down, in,
    output count, high, low
  );
endinterface

// File: rtl/updown_load_counter.sv
// Loadable up/down counter with at-max / at-zero flags.
// Latency: 1 cycle; a command sampled at a rising edge is visible right after it.
// Backpressure: none; one command accepted every cycle.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst   : asynchronous, active-low reset (count forced to 0)
//   intf  : updown_load_counter_if.slave (load/up/down/in in, count/high/low out)
//
// Build option: define COUNTER_WRAP_EN to make increment at max wrap to 0 and
// decrement at 0 wrap to max instead of saturating.
module updown_load_counter #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  updown_load_counter_if.slave     intf
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;
  logic             at_min;

  // Flags decode only the register, so input activity cannot glitch them.
  assign at_max = (count_q == CNT_MAX);
  assign at_min = (count_q == CNT_ZERO);

  // Next-count selection: load wins, then a lone up or a lone down;
  // up together with down, or no request, holds.
  always_comb begin
    count_d = count_q;
    if (intf.load) begin
      count_d = intf.in;
    end else if (intf.up && !intf.down) begin
`ifdef COUNTER_WRAP_EN
      count_d = count_q + CNT_ONE;
`else
      if (!at_max) begin
        count_d = count_q + CNT_ONE;
      end
`endif
    end else if (intf.down && !intf.up) begin
`ifdef COUNTER_WRAP_EN
      count_d = count_q - CNT_ONE;
`else
      if (!at_min) begin
        count_d = count_q - CNT_ONE;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign intf.count = count_q;
  assign intf.high  = at_max;
  assign intf.low   = at_min;

endmodule

// File: tb/tb_updown_load_counter.sv
// Self-checking bench for updown_load_counter (WIDTH=4).
// Directed vector table, hand-written reset sequence, then a randomized run
// against an arithmetic reference model of the counting rules.
module tb_updown_load_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk;
  logic rst;

  updown_load_counter_if #(.WIDTH(W)) intf ();

  updown_load_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .intf (intf.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit       load;
    bit       up;
    bit       down;
    int       in_val;
    int       exp_count;
    bit       exp_high;
    bit       exp_low;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_err;
  int   model;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input int exp_cnt);
    check({name, ".count"}, int'(intf.count), exp_cnt);
    check({name, ".high"},  int'(intf.high),  (exp_cnt == MAX) ? 1 : 0);
    check({name, ".low"},   int'(intf.low),   (exp_cnt == 0) ? 1 : 0);
  endtask

  task automatic drive(input bit ld, input bit u, input bit d, input int v);
    intf.load = ld;
    intf.up   = u;
    intf.down = d;
    intf.in   = W'(v);
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input bit ld, input bit u, input bit d, input int v,
                         input int ec);
    vec_t t;
    t.load = ld; t.up = u; t.down = d; t.in_val = v;
    t.exp_count = ec;
    t.exp_high  = (ec == MAX);
    t.exp_low   = (ec == 0);
    vecs.push_back(t);
  endtask

  // Reference model: next count from the command rules, plain integer arithmetic.
  function automatic int model_next(input int cur, input bit ld, input bit u,
                                    input bit d, input int v);
    if (ld) return v;
    if (u && !d) begin
`ifdef COUNTER_WRAP_EN
      return (cur + 1) % (MAX + 1);
`else
      return (cur == MAX) ? cur : cur + 1;
`endif
    end
    if (d && !u) begin
`ifdef COUNTER_WRAP_EN
      return (cur + MAX) % (MAX + 1);
`else
      return (cur == 0) ? cur : cur - 1;
`endif
    end
    return cur;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Directed vector table.
    add_vec(1, 0, 0, 9, 9);
    add_vec(1, 1, 1, 3, 3);
    add_vec(0, 1, 1, 0, 3);
    add_vec(1, 0, 0, 13, 13);
    add_vec(0, 1, 0, 0, 14);
    add_vec(0, 1, 0, 0, 15);
`ifdef COUNTER_WRAP_EN
    add_vec(0, 1, 0, 0, 0);
    add_vec(0, 1, 0, 0, 1);
`else
    add_vec(0, 1, 0, 0, 15);
    add_vec(0, 1, 0, 0, 15);
`endif
    add_vec(1, 0, 0, 2, 2);
    add_vec(0, 0, 1, 0, 1);
    add_vec(0, 0, 1, 0, 0);
`ifdef COUNTER_WRAP_EN
    add_vec(0, 0, 1, 0, 15);
    add_vec(0, 0, 1, 0, 14);
`else
    add_vec(0, 0, 1, 0, 0);
    add_vec(0, 0, 1, 0, 0);
`endif
    add_vec(1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 15, 15);
    add_vec(1, 0, 0, 7, 7);
    for (int i = 0; i < 10; i++) add_vec(0, 0, 0, 0, 7);

    // Reset state.
    rst = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    check_all("reset_state", 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Asynchronous reset mid-count.
    drive(1, 0, 0, 5);
    step();
    check_all("load5", 5);
    drive(0, 1, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    check_all("async_rst", 0);
    // Reset held across edges discards commands.
    drive(1, 0, 0, 9);
    step();
    check_all("rst_hold1", 0);
    step();
    check_all("rst_hold2", 0);
    rst = 1'b1;

    // Table.
    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].up, vecs[i].down, vecs[i].in_val);
      step();
      check($sformatf("vec%0d.count", i), int'(intf.count), vecs[i].exp_count);
      check($sformatf("vec%0d.high", i),  int'(intf.high),  int'(vecs[i].exp_high));
      check($sformatf("vec%0d.low", i),   int'(intf.low),   int'(vecs[i].exp_low));
    end
    model = 7;

    // Randomized run against the reference model.
    for (int c = 0; c < 1000; c++) begin
      bit ld, u, d;
      int v;
      ld = ($urandom_range(0, 7) == 0);
      u  = $urandom_range(0, 1);
      d  = $urandom_range(0, 1);
      v  = $urandom_range(0, MAX);
      drive(ld, u, d, v);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        #1;
        model = 0;
        check_all("rnd_async_rst", model);
        step();
        check_all("rnd_rst_edge", model);
        rst = 1'b1;
      end else begin
        model = model_next(model, ld, u, d, v);
        step();
        check_all($sformatf("rnd%0d", c), model);
      end
    end

    drive(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
